// File: rtl/dpram_pkg.sv
// Shared types and parameter checks for the byte-enabled single-clock dual-port RAM.
package dpram_pkg;

  typedef enum logic {
    WRITE_FIRST = 1'b0,
    READ_FIRST  = 1'b1
  } rdw_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/dpram_lane.sv
// One byte lane of the RAM: true dual-port storage with read-first registered outputs.
module dpram_lane #(
  parameter int AW = 16,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_a,
  input  logic [BW-1:0] din_a,
  input  logic          we_a,
  input  logic          re_a,
  output logic [BW-1:0] dout_a,
  input  logic [AW-1:0] addr_b,
  input  logic [BW-1:0] din_b,
  input  logic          we_b,
  input  logic          re_b,
  output logic [BW-1:0] dout_b
);

  logic [BW-1:0] mem [2**AW];

  // NOTE: the storage array has no reset so it maps onto block RAM; zeroing is the clear sweep's job.
  // Port A is applied last so it wins should both ports ever target the same word.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= din_b;
    if (we_a) mem[addr_a] <= din_a;
  end

  // NOTE: non-blocking reads here sample the pre-write word, which is what makes the lane read-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      if (re_a) dout_a <= mem[addr_a];
      if (re_b) dout_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/dpram_be_sclk.sv
// Byte-enabled single-clock true dual-port RAM with collision priority, selectable
// read-during-write, 1/2-cycle read latency and a post-reset zero-fill sweep.
module dpram_be_sclk
  import dpram_pkg::*;
#(
  parameter int        AW           = 16,
  parameter int        DW           = 16,
  parameter int        BW           = 8,
  parameter rdw_mode_t RDW_MODE     = WRITE_FIRST,
  parameter int        RD_LAT       = 1,
  parameter bit        CLEAR_ON_RST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       a_a,
  input  logic [AW-1:0]       a_b,
  input  logic [DW-1:0]       d_a,
  input  logic [DW-1:0]       d_b,
  input  logic                w_a,
  input  logic                w_b,
  input  logic [(DW/BW)-1:0]  be_a,
  input  logic [(DW/BW)-1:0]  be_b,
  input  logic                r_a,
  input  logic                r_b,
  output logic [DW-1:0]       q_a,
  output logic [DW-1:0]       q_b,
  output logic                qv_a,
  output logic                qv_b,
  output logic                coll,
  output logic                busy
);

  localparam int NB = DW / BW;

  if (!rd_lat_ok(RD_LAT) || (DW % BW) != 0) begin : g_bad_param
    $error("dpram_be_sclk: RD_LAT must be 1 or 2 and DW a multiple of BW");
  end

  // ---------------------------------------------------------------- clear FSM
  clr_state_t    state;
  logic [AW-1:0] sweep_addr;
  logic          busy_q;
  logic          sweep_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR_ON_RST ? CLEAR : IDLE;
      sweep_addr <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state)
        IDLE: busy_q <= 1'b0;
        CLEAR: begin
          sweep_addr <= sweep_addr + 1'b1;
          if (sweep_addr == '1) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sweep_we = (state == CLEAR) && !rst;
  assign busy     = busy_q;

  // --------------------------------------------------------- request qualify
  logic          accept;
  logic          rd_a, rd_b, wr_a, wr_b, same_addr;
  logic [NB-1:0] en_a, en_b;

  assign accept    = !busy_q && !rst;
  assign rd_a      = accept && r_a;
  assign rd_b      = accept && r_b;
  assign wr_a      = accept && w_a;
  assign wr_b      = accept && w_b;
  assign same_addr = (a_a == a_b);
  assign en_a      = wr_a ? be_a : '0;
  // B only lands on lanes A is not writing to the same word this cycle.
  assign en_b      = (wr_b ? be_b : '0) & ~(same_addr ? en_a : '0);

  // ------------------------------------------------------------------- lanes
  logic [AW-1:0] lane_addr_a;
  logic [DW-1:0] lane_din_a;
  logic [DW-1:0] raw_a, raw_b;

  assign lane_addr_a = sweep_we ? sweep_addr : a_a;
  assign lane_din_a  = sweep_we ? '0 : d_a;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    dpram_lane #(
      .AW(AW),
      .BW(BW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .addr_a (lane_addr_a),
      .din_a  (lane_din_a[i*BW +: BW]),
      .we_a   (sweep_we | en_a[i]),
      .re_a   (rd_a),
      .dout_a (raw_a[i*BW +: BW]),
      .addr_b (a_b),
      .din_b  (d_b[i*BW +: BW]),
      .we_b   (en_b[i]),
      .re_b   (rd_b),
      .dout_b (raw_b[i*BW +: BW])
    );
  end

  // ------------------------------------------- read-during-write and stage 1
  logic [NB-1:0] wf_mask_a, wf_mask_b;
  logic [DW-1:0] wf_data_a, wf_data_b;
  logic          v1_a, v1_b;
  logic [DW-1:0] q1_a, q1_b;

  // The lanes are read-first; write-first is built by overlaying this port's
  // own written lanes onto the lane output one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wf_mask_a <= '0;
      wf_mask_b <= '0;
      wf_data_a <= '0;
      wf_data_b <= '0;
      v1_a      <= 1'b0;
      v1_b      <= 1'b0;
    end else begin
      v1_a <= rd_a;
      v1_b <= rd_b;
      if (rd_a) begin
        wf_mask_a <= (RDW_MODE == WRITE_FIRST) ? en_a : '0;
        wf_data_a <= d_a;
      end
      if (rd_b) begin
        wf_mask_b <= (RDW_MODE == WRITE_FIRST) ? en_b : '0;
        wf_data_b <= d_b;
      end
    end
  end

  // NOTE: defaults first in always_comb so no path leaves a bit unassigned (no latch).
  always_comb begin
    q1_a = raw_a;
    q1_b = raw_b;
    for (int i = 0; i < NB; i++) begin
      if (wf_mask_a[i]) q1_a[i*BW +: BW] = wf_data_a[i*BW +: BW];
      if (wf_mask_b[i]) q1_b[i*BW +: BW] = wf_data_b[i*BW +: BW];
    end
  end

  // ---------------------------------------------------------- output stage
  logic qv_raw_a, qv_raw_b;

  if (RD_LAT == 2) begin : g_lat2
    logic [DW-1:0] q2_a, q2_b;
    logic          v2_a, v2_b;

    always_ff @(posedge clk) begin
      if (rst) begin
        q2_a <= '0;
        q2_b <= '0;
        v2_a <= 1'b0;
        v2_b <= 1'b0;
      end else begin
        v2_a <= v1_a;
        v2_b <= v1_b;
        if (v1_a) q2_a <= q1_a;
        if (v1_b) q2_b <= q1_b;
      end
    end

    assign q_a      = q2_a;
    assign q_b      = q2_b;
    assign qv_raw_a = v2_a;
    assign qv_raw_b = v2_b;
  end else begin : g_lat1
    assign q_a      = q1_a;
    assign q_b      = q1_b;
    assign qv_raw_a = v1_a;
    assign qv_raw_b = v1_b;
  end

  // A read completing while rst is high is dropped rather than reported.
  assign qv_a = qv_raw_a & ~rst;
  assign qv_b = qv_raw_b & ~rst;

  // --------------------------------------------------------------- collision
  always_ff @(posedge clk) begin
    if (rst) coll <= 1'b0;
    else     coll <= wr_a && wr_b && same_addr && ((be_a & be_b) != '0);
  end

endmodule

// File: tb/tb_dpram_be_sclk.sv
// Self-checking bench: a WRITE_FIRST/RD_LAT=1 and a READ_FIRST/RD_LAT=2 instance share
// stimulus and are compared every cycle against a word-level reference model.
module tb_dpram_be_sclk;
  import dpram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a_a, a_b;
  logic [15:0] d_a, d_b;
  logic        w_a, w_b, r_a, r_b;
  logic [1:0]  be_a, be_b;

  logic [15:0] q_a1, q_b1, q_a2, q_b2;
  logic        qv_a1, qv_b1, qv_a2, qv_b2, coll1, coll2, busy1, busy2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  dpram_be_sclk #(.AW(4), .DW(16), .BW(8), .RDW_MODE(WRITE_FIRST), .RD_LAT(1), .CLEAR_ON_RST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .a_a(a_a), .a_b(a_b), .d_a(d_a), .d_b(d_b), .w_a(w_a), .w_b(w_b),
    .be_a(be_a), .be_b(be_b), .r_a(r_a), .r_b(r_b), .q_a(q_a1), .q_b(q_b1),
    .qv_a(qv_a1), .qv_b(qv_b1), .coll(coll1), .busy(busy1));

  dpram_be_sclk #(.AW(4), .DW(16), .BW(8), .RDW_MODE(READ_FIRST), .RD_LAT(2), .CLEAR_ON_RST(1'b1)) dut2 (
    .clk(clk), .rst(rst), .a_a(a_a), .a_b(a_b), .d_a(d_a), .d_b(d_b), .w_a(w_a), .w_b(w_b),
    .be_a(be_a), .be_b(be_b), .r_a(r_a), .r_b(r_b), .q_a(q_a2), .q_b(q_b2),
    .qv_a(qv_a2), .qv_b(qv_b2), .coll(coll2), .busy(busy2));

  // ------------------------------------------------------- reference model
  logic [15:0] mem [16];
  bit          m_busy = 1'b1;
  int          sweep  = 0;
  logic [15:0] e1_qa = '0, e1_qb = '0, e2_qa = '0, e2_qb = '0;
  logic        e1_qva = 0, e1_qvb = 0, e2_qva = 0, e2_qvb = 0, e_coll = 0, e_busy = 1;
  logic        p2_va = 0, p2_vb = 0;
  logic [15:0] p2_qa = '0, p2_qb = '0;

  function automatic logic [71:0] obs_vec();
    return {busy1, busy2, coll1, coll2, qv_a1, qv_b1, qv_a2, qv_b2, q_a1, q_b1, q_a2, q_b2};
  endfunction

  function automatic logic [71:0] exp_vec();
    return {e_busy, e_busy, e_coll, e_coll, e1_qva, e1_qvb, e2_qva, e2_qvb, e1_qa, e1_qb, e2_qa, e2_qb};
  endfunction

  // Advances the model by one cycle using the currently driven inputs, then clocks the DUTs.
  task automatic step();
    logic        acc, same;
    logic [1:0]  wa_lanes, wb_lanes;
    logic [15:0] old_a, old_b, new_a, new_b;
    acc      = !m_busy && !rst;
    same     = (a_a == a_b);
    old_a    = mem[a_a];
    old_b    = mem[a_b];
    wa_lanes = (acc && w_a) ? be_a : 2'b00;
    wb_lanes = (acc && w_b) ? be_b : 2'b00;
    if (same) wb_lanes = wb_lanes & ~wa_lanes;
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < 2; i++) begin
      if (wa_lanes[i]) new_a[i*8 +: 8] = d_a[i*8 +: 8];
      if (wb_lanes[i]) new_b[i*8 +: 8] = d_b[i*8 +: 8];
    end
    if (rst) begin
      {e1_qva, e1_qvb, e2_qva, e2_qvb} = 4'b0000;
      {e1_qa, e1_qb, e2_qa, e2_qb}     = 64'h0;
      p2_va = 0;
      p2_vb = 0;
    end else begin
      e2_qva = p2_va;
      e2_qvb = p2_vb;
      if (p2_va) e2_qa = p2_qa;
      if (p2_vb) e2_qb = p2_qb;
      p2_va = acc && r_a;
      p2_vb = acc && r_b;
      if (p2_va) p2_qa = old_a;
      if (p2_vb) p2_qb = old_b;
      e1_qva = acc && r_a;
      e1_qvb = acc && r_b;
      if (e1_qva) e1_qa = new_a;
      if (e1_qvb) e1_qb = new_b;
    end
    e_coll = acc && w_a && w_b && same && ((be_a & be_b) != 2'b00);
    // B first, then A on top: A wins overlapping lanes of a shared word.
    for (int i = 0; i < 2; i++) if (acc && w_b && be_b[i]) mem[a_b][i*8 +: 8] = d_b[i*8 +: 8];
    for (int i = 0; i < 2; i++) if (acc && w_a && be_a[i]) mem[a_a][i*8 +: 8] = d_a[i*8 +: 8];
    if (rst) begin
      m_busy = 1;
      sweep  = 0;
    end else if (m_busy) begin
      mem[sweep] = '0;
      if (sweep == 15) m_busy = 0;
      sweep++;
    end
    e_busy = m_busy;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    {w_a, w_b, r_a, r_b} = 4'b0000;
    be_a = 2'b00;
    be_b = 2'b00;
    d_a  = '0;
    d_b  = '0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    int n;
    idle();
    a_a = '0;
    a_b = '0;
    rst = 1'b1;
    step();
    step();
    total++;
    if ({busy1, busy2, coll1, coll2, qv_a1, qv_b1, qv_a2, qv_b2} !== 8'b1100_0000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=11000000", {busy1, busy2, coll1, coll2, qv_a1, qv_b1, qv_a2, qv_b2});
    end
    total++;
    if ({q_a1, q_b1, q_a2, q_b2} !== 64'h0) begin
      bad++;
      $display("FAIL reset_q got=%h exp=0", {q_a1, q_b1, q_a2, q_b2});
    end
    rst = 1'b0;
    n = 0;
    while (busy1 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (n != 16 || busy2 !== 1'b0) begin
      bad++;
      $display("FAIL clear_busy_cycles got=%0d busy2=%b exp=16 busy2=0", n, busy2);
    end
    for (int w = 0; w < 16; w++) begin
      r_a = 1'b1;
      a_a = 4'(w);
      r_b = 1'b1;
      a_b = 4'(15 - w);
      step();
      total++;
      if (qv_a1 !== 1'b1 || q_a1 !== 16'h0 || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL clear_read w=%0d got=%h exp=%h", w, obs_vec(), exp_vec());
      end
    end
    idle();
    step();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL clear_flush got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_byte_merge();
    idle();
    w_a = 1'b1; a_a = 4'd3; d_a = 16'hABCD; be_a = 2'b11;
    step();
    d_a = 16'h0012; be_a = 2'b01;
    step();
    idle();
    r_b = 1'b1; a_b = 4'd3;
    step();
    total++;
    if (qv_b1 !== 1'b1 || q_b1 !== 16'hAB12) begin
      bad++;
      $display("FAIL merge_lat1 got qv=%b q=%h exp qv=1 q=ab12", qv_b1, q_b1);
    end
    idle();
    step();
    total++;
    if (qv_b1 !== 1'b0 || qv_b2 !== 1'b1 || q_b2 !== 16'hAB12 || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL merge_pulse got=%h exp=%h", obs_vec(), exp_vec());
    end
    step();
    total++;
    if (qv_b2 !== 1'b0 || q_b2 !== 16'hAB12) begin
      bad++;
      $display("FAIL merge_lat2_pulse got qv=%b q=%h exp qv=0 q=ab12", qv_b2, q_b2);
    end
  endtask

  task automatic test_rdw();
    idle();
    w_a = 1'b1; a_a = 4'd7; d_a = 16'h1111; be_a = 2'b11;
    step();
    r_a = 1'b1; d_a = 16'h2222;
    r_b = 1'b1; a_b = 4'd7;
    step();
    total++;
    if (q_a1 !== 16'h2222 || q_b1 !== 16'h1111 || qv_a1 !== 1'b1 || qv_b1 !== 1'b1) begin
      bad++;
      $display("FAIL rdw_write_first got a=%h b=%h exp a=2222 b=1111", q_a1, q_b1);
    end
    idle();
    step();
    total++;
    if (q_a2 !== 16'h1111 || q_b2 !== 16'h1111 || qv_a2 !== 1'b1 || qv_b2 !== 1'b1) begin
      bad++;
      $display("FAIL rdw_read_first got a=%h b=%h exp a=1111 b=1111", q_a2, q_b2);
    end
    r_a = 1'b1; a_a = 4'd7;
    step();
    total++;
    if (q_a1 !== 16'h2222 || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL rdw_stored got=%h exp=%h", obs_vec(), exp_vec());
    end
    idle();
    step();
  endtask

  task automatic test_collision();
    idle();
    w_a = 1'b1; a_a = 4'd5; d_a = 16'hAAAA; be_a = 2'b10;
    w_b = 1'b1; a_b = 4'd5; d_b = 16'hBBBB; be_b = 2'b11;
    step();
    total++;
    if (coll1 !== 1'b1 || coll2 !== 1'b1) begin
      bad++;
      $display("FAIL coll_high got=%b%b exp=11", coll1, coll2);
    end
    idle();
    r_a = 1'b1; a_a = 4'd5;
    step();
    total++;
    if (coll1 !== 1'b0 || coll2 !== 1'b0 || q_a1 !== 16'hAABB) begin
      bad++;
      $display("FAIL coll_result got coll=%b%b q=%h exp coll=00 q=aabb", coll1, coll2, q_a1);
    end
    idle();
    step();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL coll_flush got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 8; i++) begin
      w_a = 1'b1; be_a = 2'b11; a_a = 4'(i);
      d_a = 16'h1000 + 16'(i) * 16'h0123;
      step();
    end
    idle();
    for (int j = 0; j < 10; j++) begin
      r_a = (j < 8);
      r_b = (j < 8);
      a_a = 4'(j);
      a_b = 4'(7 - (j % 8));
      step();
      total++;
      if (qv_a2 !== (j >= 1 && j <= 8) || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL back_to_back j=%0d got=%h exp=%h", j, obs_vec(), exp_vec());
      end
    end
    idle();
  endtask

  task automatic test_random();
    int errs = 0;
    idle();
    for (int n = 0; n < 400; n++) begin
      a_a  = 4'($urandom_range(0, 15));
      a_b  = ($urandom_range(0, 3) == 0) ? a_a : 4'($urandom_range(0, 15));
      d_a  = 16'($urandom);
      d_b  = 16'($urandom);
      be_a = 2'($urandom);
      be_b = 2'($urandom);
      w_a  = ($urandom_range(0, 1) == 1);
      w_b  = ($urandom_range(0, 1) == 1);
      r_a  = ($urandom_range(0, 2) != 0);
      r_b  = ($urandom_range(0, 2) != 0);
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        errs++;
        if (errs < 10) $display("FAIL random n=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
      end
    end
    idle();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  seen_qv;
    idle();
    r_a = 1'b1; a_a = 4'd1;
    r_b = 1'b1; a_b = 4'd2;
    step();
    rst = 1'b1;
    step();
    total++;
    if ({qv_a1, qv_b1, qv_a2, qv_b2} !== 4'b0000 || busy1 !== 1'b1) begin
      bad++;
      $display("FAIL rst_inflight got qv=%b busy=%b exp qv=0000 busy=1", {qv_a1, qv_b1, qv_a2, qv_b2}, busy1);
    end
    step();
    rst = 1'b0;
    seen_qv = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      seen_qv |= qv_a1 | qv_b1 | qv_a2 | qv_b2;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (busy1 && n < 40) begin
      step();
      n++;
      seen_qv |= qv_a1 | qv_b1 | qv_a2 | qv_b2;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rst_sweep n=%0d got=%h exp=%h", n, obs_vec(), exp_vec());
      end
    end
    total++;
    if (n != 16 || seen_qv) begin
      bad++;
      $display("FAIL rst_restart got cycles=%0d qv_seen=%b exp cycles=16 qv_seen=0", n, seen_qv);
    end
    idle();
    for (int w = 0; w < 16; w += 5) begin
      r_a = 1'b1; a_a = 4'(w);
      r_b = 1'b1; a_b = 4'(w + 1);
      step();
      total++;
      if (q_a1 !== 16'h0 || q_b1 !== 16'h0 || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rst_cleared w=%0d got=%h exp=%h", w, obs_vec(), exp_vec());
      end
    end
    idle();
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_byte_merge();
    test_rdw();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpram_be_sclk.md
# dpram_be_sclk

Single-clock true dual-port RAM with per-byte write enables, selectable read-during-write behaviour, 1- or 2-cycle read latency, deterministic same-address write collision resolution and a post-reset zero-clear sweep. It is the generalised replacement for the plain dual-port buffers used between packet/driver logic and the host side. Storage is split into byte lanes so byte-masked writes from either port map cleanly onto block RAM.

## Interface
- AW, 16: address width; depth 2**AW words
- DW, 16: data width; must be an integer multiple of BW
- BW, 8: byte-lane width; NB = DW/BW lanes
- RDW_MODE, WRITE_FIRST: same-port read-during-write result (WRITE_FIRST or READ_FIRST)
- RD_LAT, 1: read latency in cycles, 1 or 2
- CLEAR_ON_RST, 1: 1 = zero-fill the whole array after reset
- clk  in  1  single clock; one clock, all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- a_a / a_b  in  AW  port A/B address
- d_a / d_b  in  DW  port A/B write data
- w_a / w_b  in  1  port A/B write strobe
- be_a / be_b  in  NB  port A/B byte enables; bit i covers d[i*BW +: BW]
- r_a / r_b  in  1  port A/B read strobe
- q_a / q_b  out  DW  port A/B read data
- qv_a / qv_b  out  1  port A/B read-data valid, one pulse per accepted read
- coll  out  1  same-address write collision flag
- busy  out  1  clear sweep in progress; all requests ignored

## Operation
- Reset values: q_a = q_b = 0, qv_a = qv_b = 0, coll = 0, busy = 1 while rst is high.
- Clear FSM states: IDLE, CLEAR. rst forces CLEAR with sweep counter = 0. In CLEAR, word[counter] is written 0 each cycle and the counter increments. After counter = 2**AW-1 is written, the next state is IDLE and busy falls. rst during CLEAR restarts the sweep from 0. With CLEAR_ON_RST = 0, rst goes straight to IDLE and busy falls on the first cycle after rst deasserts.
- While busy: r/w strobes are ignored, no qv is asserted, and array contents are touched only by the sweep.
- Write: with w_x high, lanes with be_x[i] = 1 take d_x lane i; the other lanes keep their value. w_x with be_x = 0 is a no-op.
- Read: r_x high returns the word at a_x. q_x holds its last value when no read is issued.
- Same-port r_x & w_x:
  - WRITE_FIRST returns the merged post-write word.
  - READ_FIRST returns the pre-write word.
- w_x without r_x produces no qv_x.
- Cross-port read of an address written by the other port in the same cycle always returns the pre-write word, in both modes.
- Both ports write the same address in the same cycle:
  - Per lane, A wins where be_a[i] = 1.
  - B's lanes are written where be_b[i] = 1 and be_a[i] = 0.
  - coll asserts if any lane overlaps (be_a & be_b ≠ 0).
- Same-address reads on both ports are legal; both return identical data.

## Timing
- RD_LAT = 1: request in cycle k; q_x and qv_x valid in cycle k+1.
- RD_LAT = 2: extra output register; q_x and qv_x valid in cycle k+2. The pipeline is fully throughput-1, one read per port per cycle.
- Written data is visible to a read issued on either port in cycle k+1 or later.
- coll is registered: collision in cycle k gives coll high for exactly cycle k+1.
- rst clears the qv pipeline stages the following cycle. In-flight reads are dropped, with no qv pulse.
- busy high from the rst cycle through 2**AW cycles after rst deasserts, when CLEAR_ON_RST = 1.

## Structure
- Package dpram_pkg holds:
  - rdw_mode_t enum {WRITE_FIRST, READ_FIRST}
  - clr_state_t enum {IDLE, CLEAR}
  - RD_LAT legality check
- Sub-module dpram_lane is the BW-wide true dual-port lane with per-port write enable and read-first output. It is instantiated NB times.
- The top module holds the lane enable masking, collision priority, RDW muxing, output pipeline and clear FSM.

## Test plan
- Clear sweep: AW=4, reset, then write and read after busy falls. Expect busy high for 16 cycles after rst deasserts, and all 16 words read 0.
- Byte merge: write 0xABCD with be_a=11, then 0x0012 with be_a=01; read via B. Expect q_b = 0xAB12 one cycle after r_b (RD_LAT=1) and qv_b a one-cycle pulse.
- RDW modes: word holds 0x1111; same-cycle r_a & w_a of 0x2222. Expect WRITE_FIRST q_a = 0x2222 and READ_FIRST q_a = 0x1111. In the same cycle r_b reads the same address and gets 0x1111 in both modes.
- Collision: A writes 0xAAAA be=10 and B writes 0xBBBB be=11 to address 5. Expect coll high for one cycle at k+1 and word 5 = 0xAABB.
- Latency: RD_LAT=2, back-to-back reads of addresses 0..7 on both ports. Expect qv high for 8 consecutive cycles starting at k+2, with data in order.
- Reset mid-operation: assert rst mid-sweep and with reads in flight. Expect no qv pulses, the sweep to restart, and busy high for a full 2**AW cycles after release.
